// File: rtl/ranging_pkg.sv
// ranging_pkg
//   Shared definitions for the ultrasonic ranging sequencer:
//   - state_e     : sequencer state encoding (also driven out on state_dbg)
//   - BCD_TIMEOUT : distance reported when a measurement is lost
//   - ctr_width() : bit width needed for a counter that counts 0..cycles-1
package ranging_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        TRIG      = 3'd2,
        WAIT_RISE = 3'd3,
        MEASURE   = 3'd4,
        CAPTURE   = 3'd5,
        LOST      = 3'd6,
        HOLDOFF   = 3'd7
    } state_e;

    localparam logic [11:0] BCD_TIMEOUT = 12'h999;

    // Width of a counter whose largest value is cycles-1 (never less than 1 bit).
    function automatic int ctr_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/echo_sync.sv
// echo_sync
//   Brings the asynchronous sensor echo into the clk domain and derives
//   single-cycle edge pulses from the synchronized level.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous, active-high reset (all flops to 0)
//   echo  in  raw sensor echo
//   rise  out one-cycle pulse: first cycle the synchronized echo is high
//   fall  out one-cycle pulse: first cycle the synchronized echo is low again
module echo_sync (
    input  logic clk,
    input  logic reset,
    input  logic echo,
    output logic rise,
    output logic fall
);

    logic echo_m;   // first synchronizer stage, may go metastable
    logic echo_s;   // synchronized echo level
    logic echo_d;   // echo_s delayed by one cycle for edge detection

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
            echo_d <= echo_s;
        end
    end

    assign rise = echo_s & ~echo_d;
    assign fall = ~echo_s & echo_d;

endmodule

// File: rtl/ranging_sequencer.sv
// ranging_sequencer
//   Measurement controller for the ultrasonic ranging path. Issues the
//   trigger pulse, waits for the echo, gates the external 3-digit BCD counter
//   with a distance-tick strobe while echo is high, then captures the result.
//   Single-shot (start) and free-running (auto_en) operation, with timeout.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   start      in   single-shot request, only looked at in IDLE
//   auto_en    in   level, repeat measurements every PERIOD_CYCLES
//   echo       in   asynchronous sensor echo
//   trig       out  sensor trigger pulse (TRIG_CYCLES long)
//   cnt_clr    out  one-cycle clear to the BCD counter
//   cnt_ena    out  one-cycle count strobe to the BCD counter
//   cnt_value  in   BCD counter value {hundreds,tens,units}
//   dist_bcd   out  last captured distance (12'h999 when lost)
//   dist_valid out  one-cycle pulse when dist_bcd/timeout update
//   timeout    out  1 = last measurement lost, held until next dist_valid
//   busy       out  high in every state except IDLE
//   state_dbg  out  current sequencer state (state_e encoding)
//
// Handshake: there is no back-pressure. start is a request level sampled
// only while IDLE; dist_valid is a single-cycle strobe with dist_bcd and
// timeout already stable in that cycle and held until the next strobe.
//
// Timing: ctr is 0 in CLEAR and counts every cycle, so TRIG spans
// ctr = 1..TRIG_CYCLES, the timeout fires when ctr reaches TIMEOUT_CYCLES in
// WAIT_RISE/MEASURE, and HOLDOFF ends at ctr = PERIOD_CYCLES-1, giving trigger
// starts exactly PERIOD_CYCLES apart in auto mode. TICK_DIV must be >= 2.
module ranging_sequencer #(
    parameter int unsigned TRIG_CYCLES    = 1000,
    parameter int unsigned TICK_DIV       = 5830,
    parameter int unsigned TIMEOUT_CYCLES = 3800000,
    parameter int unsigned PERIOD_CYCLES  = 6000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        auto_en,
    input  logic        echo,
    output logic        trig,
    output logic        cnt_clr,
    output logic        cnt_ena,
    input  logic [11:0] cnt_value,
    output logic [11:0] dist_bcd,
    output logic        dist_valid,
    output logic        timeout,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    import ranging_pkg::*;

    localparam int CW = ctr_width(PERIOD_CYCLES);
    localparam int DW = ctr_width(TICK_DIV);

    localparam logic [CW-1:0] TRIG_END    = CW'(TRIG_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_AT  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(PERIOD_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST    = DW'(TICK_DIV - 1);

    state_e         state_q, state_nxt;
    logic [CW-1:0]  ctr_q, ctr_nxt;
    logic [DW-1:0]  div_q, div_nxt;
    logic           echo_rise, echo_fall;
    logic           timed_out;
    logic           strobe;

    echo_sync u_echo_sync (
        .clk   (clk),
        .reset (reset),
        .echo  (echo),
        .rise  (echo_rise),
        .fall  (echo_fall)
    );

    assign timed_out = (ctr_q >= TIMEOUT_AT);
    assign state_dbg = state_q;

    // Next state, cycle timer and tick divider.
    always_comb begin
        state_nxt = state_q;
        ctr_nxt   = ctr_q + CW'(1);
        div_nxt   = div_q;
        strobe    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start || auto_en) state_nxt = CLEAR;
            end
            CLEAR: begin
                state_nxt = TRIG;
            end
            TRIG: begin
                if (ctr_q >= TRIG_END) state_nxt = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (timed_out) begin
                    state_nxt = LOST;
                end else if (echo_rise) begin
                    // The rise cycle is already the first echo-high cycle and
                    // counts as divider value 0; this makes N high cycles give
                    // floor(N/TICK_DIV) strobes with none in the fall cycle.
                    state_nxt = MEASURE;
                    div_nxt   = DW'(1);
                end
            end
            MEASURE: begin
                if (timed_out) begin
                    state_nxt = LOST;
                end else if (echo_fall) begin
                    state_nxt = CAPTURE;
                end else begin
                    strobe  = (div_q == DIV_LAST);
                    div_nxt = strobe ? '0 : div_q + DW'(1);
                end
            end
            CAPTURE: begin
                state_nxt = HOLDOFF;
            end
            LOST: begin
                state_nxt = HOLDOFF;
            end
            HOLDOFF: begin
                if (ctr_q >= PERIOD_LAST) state_nxt = auto_en ? CLEAR : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // The timer restarts at every trigger sequence and rests at 0 in IDLE.
        if (state_nxt == CLEAR || state_nxt == IDLE) ctr_nxt = '0;
    end

    // State, counters and registered outputs. Pin-facing outputs are derived
    // from the next state so they line up exactly with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ctr_q      <= '0;
            div_q      <= '0;
            trig       <= 1'b0;
            cnt_clr    <= 1'b0;
            cnt_ena    <= 1'b0;
            busy       <= 1'b0;
            dist_valid <= 1'b0;
            dist_bcd   <= 12'h000;
            timeout    <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            ctr_q      <= ctr_nxt;
            div_q      <= div_nxt;
            trig       <= (state_nxt == TRIG);
            cnt_clr    <= (state_nxt == CLEAR);
            busy       <= (state_nxt != IDLE);
            cnt_ena    <= strobe;
            dist_valid <= (state_q == CAPTURE) || (state_q == LOST);
            if (state_q == CAPTURE) begin
                dist_bcd <= cnt_value;
                timeout  <= 1'b0;
            end else if (state_q == LOST) begin
                dist_bcd <= BCD_TIMEOUT;
                timeout  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ranging_sequencer.sv
// Directed bench for ranging_sequencer with a behavioural BCD counter.
module tb_ranging_sequencer;

    localparam int unsigned P_TRIG    = 4;
    localparam int unsigned P_DIV     = 10;
    localparam int unsigned P_TIMEOUT = 200;
    localparam int unsigned P_PERIOD  = 400;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        auto_en = 1'b0;
    logic        echo = 1'b0;
    logic        trig, cnt_clr, cnt_ena, dist_valid, timeout, busy;
    logic [11:0] cnt_value;
    logic [11:0] dist_bcd;
    logic [2:0]  state_dbg;

    int vec_count   = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Monitor statistics (cleared by the driver while the DUT is idle).
    int   trig_cycles = 0;
    int   trig_rises  = 0;
    int   ena_count   = 0;
    int   dv_count    = 0;
    int   dv_cyc      = 0;
    logic trig_prev   = 1'b0;

    logic [12:0] exp_q[$];   // {timeout, dist_bcd}

    ranging_sequencer #(
        .TRIG_CYCLES    (P_TRIG),
        .TICK_DIV       (P_DIV),
        .TIMEOUT_CYCLES (P_TIMEOUT),
        .PERIOD_CYCLES  (P_PERIOD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .auto_en    (auto_en),
        .echo       (echo),
        .trig       (trig),
        .cnt_clr    (cnt_clr),
        .cnt_ena    (cnt_ena),
        .cnt_value  (cnt_value),
        .dist_bcd   (dist_bcd),
        .dist_valid (dist_valid),
        .timeout    (timeout),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural BCD counter ----------------
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] u, t, h;
        u = v[3:0]; t = v[7:4]; h = v[11:8];
        if (u == 4'd9) begin
            u = 4'd0;
            if (t == 4'd9) begin
                t = 4'd0;
                h = (h == 4'd9) ? 4'd0 : h + 4'd1;
            end else begin
                t = t + 4'd1;
            end
        end else begin
            u = u + 4'd1;
        end
        return {h, t, u};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset)        cnt_value <= 12'h000;
        else if (cnt_clr) cnt_value <= 12'h000;
        else if (cnt_ena) cnt_value <= bcd_inc(cnt_value);
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expired(input string name);
        vec_count++;
        miscompares++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (trig) trig_cycles++;
            if (trig && !trig_prev) trig_rises++;
            trig_prev = trig;
            if (cnt_ena) ena_count++;
            if (dist_valid) begin
                dv_count++;
                dv_cyc = cyc;
                if (exp_q.size() == 0) begin
                    expired("unexpected_dist_valid");
                end else begin
                    check("dist_result", {19'd0, timeout, dist_bcd}, {19'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_stats();
        trig_cycles = 0; trig_rises = 0; ena_count = 0; dv_count = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_trig(input logic level, input int budget, input string name);
        int n = 0;
        while (trig !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (trig !== level) expired(name);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) expired(name);
    endtask

    // Drive echo high for n clock edges, starting gap cycles after trig falls.
    task automatic echo_after_trig(input int gap, input int n);
        wait_trig(1'b1, 600, "trig_rise");
        wait_trig(1'b0, 20, "trig_fall");
        repeat (gap) @(negedge clk);
        echo = 1'b1;
        repeat (n) @(negedge clk);
        echo = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int t0;
        int rise_t[3];
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_trig", trig, 0);
        check("rst_cnt_clr", cnt_clr, 0);
        check("rst_cnt_ena", cnt_ena, 0);
        check("rst_dist_valid", dist_valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_dist_bcd", dist_bcd, 12'h000);
        check("rst_state", state_dbg, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 1: single shot, 35 echo cycles -> 3 strobes, 003
        clear_stats();
        exp_q.push_back({1'b0, 12'h003});
        pulse_start();
        echo_after_trig(20, 35);
        wait_idle(600, "single_idle");
        check("single_trig_cycles", trig_cycles, 4);
        check("single_strobes", ena_count, 3);
        check("single_dv_count", dv_count, 1);
        check("single_state_idle", state_dbg, 0);

        // 2: no echo -> lost at ctr=200, IDLE after ctr=399
        clear_stats();
        exp_q.push_back({1'b1, 12'h999});
        pulse_start();
        wait_trig(1'b1, 20, "noecho_trig");
        t0 = cyc;
        wait_idle(800, "noecho_idle");
        check("noecho_idle_time", cyc - t0, 399);
        check("noecho_dv_time", dv_cyc - t0, 201);
        check("noecho_dv_count", dv_count, 1);
        check("noecho_strobes", ena_count, 0);

        // 3: echo stuck high before trigger -> lost
        clear_stats();
        echo = 1'b1;
        repeat (5) @(negedge clk);
        exp_q.push_back({1'b1, 12'h999});
        pulse_start();
        wait_trig(1'b1, 20, "stuck_trig");
        wait_idle(800, "stuck_idle");
        echo = 1'b0;
        check("stuck_strobes", ena_count, 0);
        check("stuck_dv_count", dv_count, 1);
        repeat (5) @(negedge clk);

        // 4: auto mode, 127 echo cycles -> 012 each, triggers 400 apart
        clear_stats();
        auto_en = 1'b1;
        for (int s = 0; s < 3; s++) begin
            exp_q.push_back({1'b0, 12'h012});
            wait_trig(1'b1, 600, "auto_trig");
            rise_t[s] = cyc;
            wait_trig(1'b0, 20, "auto_trig_fall");
            repeat (20) @(negedge clk);
            echo = 1'b1;
            if (s == 2) begin
                repeat (50) @(negedge clk);
                auto_en = 1'b0;     // dropped mid-MEASURE
                repeat (77) @(negedge clk);
            end else begin
                repeat (127) @(negedge clk);
            end
            echo = 1'b0;
        end
        wait_idle(600, "auto_idle");
        repeat (10) @(negedge clk);
        check("auto_gap0", rise_t[1] - rise_t[0], 400);
        check("auto_gap1", rise_t[2] - rise_t[1], 400);
        check("auto_trig_rises", trig_rises, 3);
        check("auto_dv_count", dv_count, 3);
        check("auto_strobes", ena_count, 36);
        check("auto_stays_idle", busy, 0);

        // 5: start while busy is ignored
        clear_stats();
        exp_q.push_back({1'b0, 12'h003});
        pulse_start();
        wait_trig(1'b1, 20, "busy_trig");
        pulse_start();                      // during TRIG
        wait_trig(1'b0, 20, "busy_trig_fall");
        repeat (20) @(negedge clk);
        echo = 1'b1;
        repeat (35) @(negedge clk);
        echo = 1'b0;
        n = 0;
        while (dv_count == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (dv_count == 0) expired("busy_dv_wait");
        repeat (3) @(negedge clk);
        pulse_start();                      // during HOLDOFF
        wait_idle(600, "busy_idle");
        repeat (10) @(negedge clk);
        check("busy_trig_rises", trig_rises, 1);
        check("busy_dv_count", dv_count, 1);
        check("busy_stays_idle", busy, 0);

        // 6: reset in MEASURE, then a normal measurement
        clear_stats();
        pulse_start();
        wait_trig(1'b1, 20, "rstm_trig");
        wait_trig(1'b0, 20, "rstm_trig_fall");
        repeat (5) @(negedge clk);
        echo = 1'b1;
        n = 0;
        while (cnt_ena !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (cnt_ena !== 1'b1) expired("rstm_strobe_wait");
        reset = 1'b1;
        #1;
        check("rstm_trig", trig, 0);
        check("rstm_cnt_ena", cnt_ena, 0);
        check("rstm_busy", busy, 0);
        check("rstm_dist_bcd", dist_bcd, 12'h000);
        repeat (3) @(negedge clk);
        echo = 1'b0;
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("rstm_no_dv", dv_count, 0);
        check("rstm_idle", busy, 0);

        clear_stats();
        exp_q.push_back({1'b0, 12'h002});
        pulse_start();
        echo_after_trig(10, 29);
        wait_idle(600, "post_rst_idle");
        check("post_rst_strobes", ena_count, 2);
        check("post_rst_dv_count", dv_count, 1);

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/ranging_sequencer.md
Name: ranging_sequencer

Overview:
Measurement controller for the ultrasonic ranging path. It issues the sensor trigger pulse and waits for the echo. While echo is high, it gates the downstream 3-digit BCD echo counter with a distance-tick strobe, then captures the counter result. Sits between the sensor pins and the BCD counter/display path, supporting single-shot and free-running measurement with echo timeout.

Parameters:
TRIG_CYCLES, 1000, trigger high time in clk cycles (10 us at 100 MHz)
TICK_DIV, 5830, clk cycles per counter increment (1 cm round trip at 100 MHz)
TIMEOUT_CYCLES, 3800000, max cycles from trigger start to echo fall before a measurement is declared lost
PERIOD_CYCLES, 6000000, minimum cycles from one trigger start to the next; must exceed TIMEOUT_CYCLES+4

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-shot request, sampled in IDLE only
auto_en  in  1  level; free-running repeated measurements
echo  in  1  asynchronous sensor echo
trig  out  1  sensor trigger pulse
cnt_clr  out  1  one-cycle clear to BCD counter
cnt_ena  out  1  one-cycle count strobe to BCD counter
cnt_value  in  12  BCD counter value {hundreds,tens,units}
dist_bcd  out  12  last captured distance, BCD
dist_valid  out  1  one-cycle pulse when dist_bcd/timeout update
timeout  out  1  1 = last measurement lost; held until next dist_valid
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async): state IDLE; trig, cnt_clr, cnt_ena, dist_valid, timeout, busy = 0; dist_bcd = 12'h000; all internal counters 0.
- echo passes a 2-flop synchronizer (echo_s), plus one delay flop (echo_d). Rise = echo_s & ~echo_d; fall = ~echo_s & echo_d.
- A cycle timer (ctr) starts at 0 on CLEAR entry and increments every cycle until IDLE. It drives the timeout and period checks.
- IDLE: if start|auto_en -> CLEAR.
- CLEAR (1 cycle): cnt_clr=1 -> TRIG.
- TRIG: trig=1 for exactly TRIG_CYCLES cycles -> WAIT_RISE.
- WAIT_RISE: on rise -> MEASURE, with the tick divider reset to 0. An echo already high on entry does not qualify. If ctr reaches TIMEOUT_CYCLES first -> LOST.
- MEASURE: the tick divider counts 0..TICK_DIV-1. cnt_ena=1 in the cycle it equals TICK_DIV-1, and the divider wraps to 0. Echo high for N synchronized cycles yields floor(N/TICK_DIV) strobes. On fall -> CAPTURE, with no strobe in the fall cycle. If ctr reaches TIMEOUT_CYCLES first -> LOST.
- CAPTURE (1 cycle, counter settles): on exit, dist_bcd<=cnt_value, timeout<=0, dist_valid=1 in the next cycle -> HOLDOFF.
- LOST (1 cycle): on exit, dist_bcd<=12'h999, timeout<=1, dist_valid=1 next cycle -> HOLDOFF.
- HOLDOFF: wait until ctr >= PERIOD_CYCLES-1. Then if auto_en -> CLEAR (ctr restarts), else -> IDLE.
- start outside IDLE is ignored (not queued).
- Dropping auto_en mid-measurement completes the current measurement, then returns to IDLE.
- Counter saturation is the counter's concern: 999 then wrap. No overflow detection here; the timeout bounds range.
- Reset mid-operation: trig and cnt_ena drop immediately; no dist_valid is issued for the aborted measurement.
- All outputs are registered; no combinational path from echo or start to outputs.

Decomposition:
- Package ranging_pkg: state enumeration (IDLE, CLEAR, TRIG, WAIT_RISE, MEASURE, CAPTURE, LOST, HOLDOFF), BCD_TIMEOUT = 12'h999, and a counter width function (clog2 of PERIOD_CYCLES).
- Sub-module echo_sync: 2-flop synchronizer, delay flop, rise/fall pulses, async reset to 0.

Test Plan:
Bench parameters: TRIG_CYCLES=4, TICK_DIV=10, TIMEOUT_CYCLES=200, PERIOD_CYCLES=400, with a behavioural BCD counter attached.
- Single shot: start pulse, echo rises 20 cycles after trig falls and stays high 35 cycles -> trig high exactly 4 cycles, 3 cnt_ena strobes, dist_bcd=12'h003, timeout=0, one dist_valid, then IDLE.
- No echo: start, echo held low -> at ctr=200 dist_bcd=12'h999, timeout=1, dist_valid once, IDLE after ctr=399.
- Echo stuck high from before trigger -> no MEASURE entry, LOST path, dist_bcd=12'h999.
- Auto mode: auto_en=1, echo high 127 cycles per shot -> successive trig rising edges exactly 400 cycles apart, each result dist_bcd=12'h012. Clearing auto_en mid-MEASURE -> result still reported, then IDLE.
- Start while busy (start pulses in TRIG and HOLDOFF) -> ignored, exactly one measurement.
- Reset asserted in MEASURE -> trig/cnt_ena/busy low same cycle, dist_bcd=12'h000, no dist_valid. After release, start -> normal measurement.
